// File: rtl/verin_avalon_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port OCI debug RAM between JTAG strobes and an Avalon slave.
// Write responds 2 cycles after grant, read RD_LAT+2; Avalon is stalled via av_waitrequest except in its ISSUE cycle.
module verin_avalon_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              jtag_req,
    input  logic              jtag_write,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [31:0]       jtag_wdata,
    output logic              jtag_ack,
    output logic [31:0]       jtag_rdata,
    output logic              jtag_overrun,
    input  logic              jtag_overrun_clr,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [ADDR_W-1:0] av_address,
    input  logic [31:0]       av_writedata,
    output logic              av_waitrequest,
    output logic [31:0]       av_readdata,
    output logic              av_readdatavalid,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic                pend_q, pend_d;
    logic                pj_we_q, pj_we_d;
    logic [ADDR_W-1:0]   pj_addr_q, pj_addr_d;
    logic [31:0]         pj_wdata_q, pj_wdata_d;
    logic                ovr_q, ovr_d;
    logic                last_av_q, last_av_d;
    logic                gnt_av_q, gnt_av_d;
    logic                op_we_q, op_we_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                ram_cs_q, ram_cs_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]         ram_wdata_q, ram_wdata_d;
    logic                jtag_ack_q, jtag_ack_d;
    logic [31:0]         jtag_rdata_q, jtag_rdata_d;
    logic                av_rdv_q, av_rdv_d;
    logic [31:0]         av_rdata_q, av_rdata_d;
    logic                jtag_vld, av_vld, pick_av, pend_eff;

    always_comb begin
        state_d      = state_q;
        last_av_d    = last_av_q;
        gnt_av_d     = gnt_av_q;
        op_we_d      = op_we_q;
        cnt_d        = cnt_q;
        ram_cs_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        jtag_ack_d   = 1'b0;
        jtag_rdata_d = jtag_rdata_q;
        av_rdv_d     = 1'b0;
        av_rdata_d   = av_rdata_q;
        pj_we_d      = pj_we_q;
        pj_addr_d    = pj_addr_q;
        pj_wdata_d   = pj_wdata_q;
        ovr_d        = ovr_q & ~jtag_overrun_clr;

        jtag_vld = pend_q | jtag_req;
        av_vld   = av_read | av_write;
        pick_av  = av_vld & (~jtag_vld | ~last_av_q);

        // The ack cycle frees the command slot before a same-cycle strobe is judged.
        pend_eff = pend_q & ~((state_q == DONE) & ~gnt_av_q);
        pend_d   = pend_eff;
        if (jtag_req) begin
            if (pend_eff) begin
                ovr_d = 1'b1;
            end else begin
                pend_d     = 1'b1;
                pj_we_d    = jtag_write;
                pj_addr_d  = jtag_addr;
                pj_wdata_d = jtag_wdata;
            end
        end

        case (state_q)
            IDLE: begin
                if (jtag_vld | av_vld) begin
                    state_d   = ISSUE;
                    gnt_av_d  = pick_av;
                    last_av_d = pick_av;
                    ram_cs_d  = 1'b1;
                    if (pick_av) begin
                        op_we_d     = av_write & ~av_read;
                        ram_addr_d  = av_address;
                        ram_wdata_d = av_writedata;
                    end else if (pend_q) begin
                        op_we_d     = pj_we_q;
                        ram_addr_d  = pj_addr_q;
                        ram_wdata_d = pj_wdata_q;
                    end else begin
                        op_we_d     = jtag_write;
                        ram_addr_d  = jtag_addr;
                        ram_wdata_d = jtag_wdata;
                    end
                    ram_we_d = op_we_d;
                end
            end
            ISSUE: begin
                if (op_we_q) begin
                    state_d    = DONE;
                    jtag_ack_d = ~gnt_av_q;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 2'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = DONE;
                    if (gnt_av_q) begin
                        av_rdv_d   = 1'b1;
                        av_rdata_d = ram_rdata;
                    end else begin
                        jtag_ack_d   = 1'b1;
                        jtag_rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pend_q       <= 1'b0;
            pj_we_q      <= 1'b0;
            pj_addr_q    <= '0;
            pj_wdata_q   <= '0;
            ovr_q        <= 1'b0;
            last_av_q    <= 1'b1;
            gnt_av_q     <= 1'b0;
            op_we_q      <= 1'b0;
            cnt_q        <= 2'd0;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            jtag_ack_q   <= 1'b0;
            jtag_rdata_q <= '0;
            av_rdv_q     <= 1'b0;
            av_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pj_we_q      <= pj_we_d;
            pj_addr_q    <= pj_addr_d;
            pj_wdata_q   <= pj_wdata_d;
            ovr_q        <= ovr_d;
            last_av_q    <= last_av_d;
            gnt_av_q     <= gnt_av_d;
            op_we_q      <= op_we_d;
            cnt_q        <= cnt_d;
            ram_cs_q     <= ram_cs_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            jtag_ack_q   <= jtag_ack_d;
            jtag_rdata_q <= jtag_rdata_d;
            av_rdv_q     <= av_rdv_d;
            av_rdata_q   <= av_rdata_d;
        end
    end

    assign av_waitrequest   = (av_read | av_write) & ~((state_q == ISSUE) & gnt_av_q);
    assign jtag_ack         = jtag_ack_q;
    assign jtag_rdata       = jtag_rdata_q;
    assign jtag_overrun     = ovr_q;
    assign av_readdata      = av_rdata_q;
    assign av_readdatavalid = av_rdv_q;
    assign ram_cs           = ram_cs_q;
    assign ram_we           = ram_we_q;
    assign ram_addr         = ram_addr_q;
    assign ram_wdata        = ram_wdata_q;
endmodule

// File: tb/tb_verin_avalon_ocimem_arbiter.sv
// Bench for the OCI memory arbiter: RAM model with RD_LAT=2 plus response scoreboards for both requesters.
module tb_verin_avalon_ocimem_arbiter;
    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic jtag_req = 1'b0, jtag_write = 1'b0, jtag_overrun_clr = 1'b0;
    logic [ADDR_W-1:0] jtag_addr = '0, av_address = '0;
    logic [31:0] jtag_wdata = '0, av_writedata = '0;
    logic av_read = 1'b0, av_write = 1'b0;
    logic jtag_ack, jtag_overrun, av_waitrequest, av_readdatavalid, ram_cs, ram_we;
    logic [31:0] jtag_rdata, av_readdata, ram_wdata, ram_rdata;
    logic [ADDR_W-1:0] ram_addr;

    int total = 0;
    int bad = 0;
    logic [31:0] jq[$];
    logic [31:0] aq[$];
    logic [7:0] acc_q[$];
    logic [31:0] jtag_last = '0;
    logic [31:0] mem [256];
    logic [31:0] rd_p0 = '0, rd_p1 = '0;

    verin_avalon_ocimem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .jtag_req(jtag_req), .jtag_write(jtag_write), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
        .jtag_ack(jtag_ack), .jtag_rdata(jtag_rdata), .jtag_overrun(jtag_overrun),
        .jtag_overrun_clr(jtag_overrun_clr),
        .av_read(av_read), .av_write(av_write), .av_address(av_address), .av_writedata(av_writedata),
        .av_waitrequest(av_waitrequest), .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: read data valid two cycles after the ram_cs cycle.
    assign ram_rdata = rd_p1;
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] = ram_wdata;
        rd_p0 <= (ram_cs && !ram_we) ? mem[ram_addr] : 32'h0;
        rd_p1 <= rd_p0;
    end

    // Scoreboard and access log.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ram_cs) acc_q.push_back(ram_addr);
            if (ram_we && !ram_cs) begin
                total++; bad++;
                $display("FAIL ram_we_without_cs: ram_we=1 ram_cs=0, required ram_cs=1");
            end
            if (jtag_ack) begin
                total++;
                if (jq.size() == 0) begin
                    bad++;
                    $display("FAIL jtag_ack_unexpected: ack with rdata=%h, required no ack", jtag_rdata);
                end else begin
                    logic [31:0] e;
                    e = jq.pop_front();
                    if (jtag_rdata !== e) begin
                        bad++;
                        $display("FAIL jtag_rdata: got %h, required %h", jtag_rdata, e);
                    end
                end
            end
            if (av_readdatavalid) begin
                total++;
                if (aq.size() == 0) begin
                    bad++;
                    $display("FAIL av_rdv_unexpected: readdatavalid with %h, required none", av_readdata);
                end else begin
                    logic [31:0] e;
                    e = aq.pop_front();
                    if (av_readdata !== e) begin
                        bad++;
                        $display("FAIL av_readdata: got %h, required %h", av_readdata, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        jq.delete(); aq.delete(); acc_q.delete();
        jtag_last = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while ((jq.size() != 0 || aq.size() != 0) && n < 100) begin
            tick(); n++;
        end
        total++;
        if (jq.size() != 0 || aq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: jq=%0d aq=%0d pending, required 0", jq.size(), aq.size());
            jq.delete(); aq.delete();
        end
        repeat (2) tick();
    endtask

    task automatic jtag_pulse(input logic wr, input logic [7:0] a, input logic [31:0] d);
        jtag_req = 1'b1; jtag_write = wr; jtag_addr = a; jtag_wdata = d;
        tick();
        jtag_req = 1'b0;
    endtask

    task automatic av_xfer(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d,
                           output int waited);
        logic we_eff;
        we_eff = wr & ~rd;
        av_read = rd; av_write = wr; av_address = a; av_writedata = d;
        if (rd) aq.push_back(mem[a]);
        waited = 0;
        while (waited <= 60) begin
            @(negedge clk);
            if (!av_waitrequest) break;
            waited++;
        end
        total++;
        if (av_waitrequest) begin
            bad++;
            $display("FAIL av_accept_timeout: waitrequest stuck at 1, required 0");
        end else if (ram_cs !== 1'b1 || ram_we !== we_eff || ram_addr !== a || (we_eff && ram_wdata !== d)) begin
            bad++;
            $display("FAIL av_issue: cs=%b we=%b addr=%h wdata=%h, required cs=1 we=%b addr=%h",
                     ram_cs, ram_we, ram_addr, ram_wdata, we_eff, a);
        end
        @(posedge clk); #1;
        av_read = 1'b0; av_write = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; av_read = 1'b1; av_address = 8'h01;
        #3;
        total++;
        if ({jtag_ack, jtag_rdata, av_readdata, av_readdatavalid, ram_cs, ram_we, ram_addr, ram_wdata, jtag_overrun}
            !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ack=%b jr=%h ar=%h rdv=%b cs=%b we=%b addr=%h wd=%h ovr=%b, required all 0",
                     jtag_ack, jtag_rdata, av_readdata, av_readdatavalid, ram_cs, ram_we, ram_addr, ram_wdata,
                     jtag_overrun);
        end
        total++;
        if (av_waitrequest !== 1'b1) begin
            bad++;
            $display("FAIL reset_waitrequest: got %b, required 1", av_waitrequest);
        end
        av_read = 1'b0;
        apply_reset();
    endtask

    task automatic test_jtag_read_latency();
        mem[8'h12] = 32'hDEADBEEF;
        jq.push_back(32'hDEADBEEF); jtag_last = 32'hDEADBEEF;
        jtag_pulse(1'b0, 8'h12, 32'h0);
        total++;
        if (ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h12) begin
            bad++;
            $display("FAIL jrd_issue_t1: cs=%b we=%b addr=%h, required cs=1 we=0 addr=12", ram_cs, ram_we, ram_addr);
        end
        tick(); tick();
        total++;
        if (jtag_ack !== 1'b0 || ram_cs !== 1'b0) begin
            bad++;
            $display("FAIL jrd_early: ack=%b cs=%b at t+3, required 0 0", jtag_ack, ram_cs);
        end
        tick();
        total++;
        if (jtag_ack !== 1'b1 || jtag_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL jrd_ack_t4: ack=%b rdata=%h, required 1 deadbeef", jtag_ack, jtag_rdata);
        end
        drain();
    endtask

    task automatic test_tie();
        int w;
        apply_reset();
        jq.push_back(mem[8'h20]); jtag_last = mem[8'h20];
        jtag_req = 1'b1; jtag_write = 1'b0; jtag_addr = 8'h20;
        fork
            begin tick(); jtag_req = 1'b0; end
            av_xfer(1'b1, 1'b0, 8'h30, 32'h0, w);
        join
        total++;
        if (w != 6) begin
            bad++;
            $display("FAIL tie_wait: av waited %0d cycles, required 6", w);
        end
        drain();
        total++;
        if (acc_q.size() != 2 || acc_q[0] !== 8'h20 || acc_q[1] !== 8'h30) begin
            bad++;
            $display("FAIL tie_order: %0d accesses first=%h, required 2 accesses 20 then 30",
                     acc_q.size(), acc_q.size() > 0 ? acc_q[0] : 8'hxx);
        end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_ord [5];
        exp_ord = '{8'h40, 8'h50, 8'h41, 8'h42, 8'h43};
        acc_q.delete();
        fork
            begin
                int w;
                for (int i = 0; i < 4; i++) av_xfer(1'b1, 1'b0, 8'h40 + 8'(i), 32'h0, w);
            end
            begin
                tick(); tick();
                jq.push_back(mem[8'h50]); jtag_last = mem[8'h50];
                jtag_pulse(1'b0, 8'h50, 32'h0);
            end
        join
        drain();
        total++;
        if (acc_q.size() != 5) begin
            bad++;
            $display("FAIL fair_count: %0d accesses, required 5", acc_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (acc_q[i] !== exp_ord[i]) begin
                    bad++;
                    $display("FAIL fair_order[%0d]: addr %h, required %h", i, acc_q[i], exp_ord[i]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        acc_q.delete();
        jq.push_back(mem[8'h60]); jtag_last = mem[8'h60];
        jtag_pulse(1'b0, 8'h60, 32'h0);
        jtag_pulse(1'b0, 8'h61, 32'h0);
        total++;
        if (jtag_overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set: got %b, required 1", jtag_overrun);
        end
        drain();
        total++;
        if (acc_q.size() != 1 || acc_q[0] !== 8'h60) begin
            bad++;
            $display("FAIL overrun_single_access: %0d accesses, required 1 at 60", acc_q.size());
        end
        jtag_overrun_clr = 1'b1; tick(); jtag_overrun_clr = 1'b0;
        total++;
        if (jtag_overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clr: got %b, required 0", jtag_overrun);
        end
        jq.push_back(mem[8'h62]); jtag_last = mem[8'h62];
        jtag_pulse(1'b0, 8'h62, 32'h0);
        jtag_overrun_clr = 1'b1;
        jtag_pulse(1'b0, 8'h63, 32'h0);
        jtag_overrun_clr = 1'b0;
        total++;
        if (jtag_overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set_wins: got %b, required 1", jtag_overrun);
        end
        drain();
        jtag_overrun_clr = 1'b1; tick(); jtag_overrun_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        jtag_pulse(1'b0, 8'h12, 32'h0);
        tick();
        reset_n = 1'b0;
        #1;
        total++;
        if ({jtag_ack, jtag_rdata, av_readdatavalid, ram_cs, ram_we, jtag_overrun} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: ack=%b jr=%h rdv=%b cs=%b we=%b ovr=%b, required all 0",
                     jtag_ack, jtag_rdata, av_readdatavalid, ram_cs, ram_we, jtag_overrun);
        end
        jq.delete(); aq.delete(); jtag_last = '0;
        tick(); tick();
        reset_n = 1'b1;
        repeat (6) tick();
        jq.push_back(32'h0);
        jtag_pulse(1'b1, 8'h70, 32'h12345678);
        total++;
        if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h70 || ram_wdata !== 32'h12345678) begin
            bad++;
            $display("FAIL post_reset_write: cs=%b we=%b addr=%h wd=%h, required 1 1 70 12345678",
                     ram_cs, ram_we, ram_addr, ram_wdata);
        end
        drain();
        jq.push_back(32'h12345678); jtag_last = 32'h12345678;
        jtag_pulse(1'b0, 8'h70, 32'h0);
        drain();
    endtask

    task automatic test_av_write();
        int w;
        logic [31:0] keep;
        av_xfer(1'b0, 1'b1, 8'h03, 32'h00000055, w);
        repeat (4) tick();
        total++;
        if (mem[8'h03] !== 32'h00000055) begin
            bad++;
            $display("FAIL av_write_mem: mem[3]=%h, required 00000055", mem[8'h03]);
        end
        keep = mem[8'h30];
        av_xfer(1'b1, 1'b1, 8'h30, 32'hFFFFFFFF, w);
        drain();
        total++;
        if (mem[8'h30] !== keep) begin
            bad++;
            $display("FAIL av_rw_as_read: mem[30]=%h, required %h", mem[8'h30], keep);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 ^ (32'(i) * 32'h00010101);
        test_reset();
        test_jtag_read_latency();
        test_tie();
        test_fairness();
        test_overrun();
        test_reset_mid();
        test_av_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
